// File: rtl/full_adder_pkg.sv
// Shared constants and golden reference for the full_adder leaf cell.
package full_adder_pkg;

  localparam int unsigned FA_MAX_WIDTH = 64;

  // Exact (WIDTH+1)-bit result of a + b + cin at maximum width; callers truncate.
  function automatic logic [FA_MAX_WIDTH:0] fa_ref(
    input logic [FA_MAX_WIDTH-1:0] a,
    input logic [FA_MAX_WIDTH-1:0] b,
    input logic                    cin
  );
    return (FA_MAX_WIDTH+1)'(a) + (FA_MAX_WIDTH+1)'(b) + (FA_MAX_WIDTH+1)'(cin);
  endfunction

endpackage

// File: rtl/full_adder_half_adder.sv
// Half-adder cell: s = x ^ y, c = x & y.
module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);

  assign s = x ^ y;
  assign c = x & y;

endmodule

// File: rtl/full_adder.sv
// Ripple-carry adder from half-adder cells, with a registered copy of the result.
// Optional FULL_ADDER_OVF_EN adds signed-overflow outputs ovf / ovf_q.
module full_adder
  import full_adder_pkg::*;
#(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum_q,
  output logic             cout_q
`ifdef FULL_ADDER_OVF_EN
  ,
  output logic             ovf,
  output logic             ovf_q
`endif
);

  logic [WIDTH:0] carry;

  assign carry[0] = cin;

  // Each bit: HA1(a,b) -> (p,g1); HA2(p,c) -> (s,g2); carry out = g1 | g2.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic p;
    logic g1;
    logic g2;

    half_adder u_ha1 (
      .x (a[i]),
      .y (b[i]),
      .s (p),
      .c (g1)
    );

    half_adder u_ha2 (
      .x (p),
      .y (carry[i]),
      .s (sum[i]),
      .c (g2)
    );

    assign carry[i+1] = g1 | g2;
  end

  assign cout = carry[WIDTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      sum_q  <= sum;
      cout_q <= cout;
    end
  end

`ifdef FULL_ADDER_OVF_EN
  assign ovf = carry[WIDTH] ^ carry[WIDTH-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf;
  end
`endif

endmodule

// File: tb/tb_full_adder.sv
// Directed and pseudo-random checks of full_adder at WIDTH = 1, 4, 8 and 16.
module tb_full_adder;
  import full_adder_pkg::*;

  logic clk;
  logic rst_n;

  logic        a1, b1, cin1, sum1, cout1, sum1_q, cout1_q;
  logic [3:0]  a4, b4, sum4, sum4_q;
  logic        cin4, cout4, cout4_q;
  logic [7:0]  a8, b8, sum8, sum8_q;
  logic        cin8, cout8, cout8_q;
  logic [15:0] a16, b16, sum16, sum16_q;
  logic        cin16, cout16, cout16_q;
`ifdef FULL_ADDER_OVF_EN
  logic ovf1, ovf1_q, ovf4, ovf4_q, ovf8, ovf8_q, ovf16, ovf16_q;
`endif

  int n_pass;
  int n_total;

  full_adder #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst_n(rst_n), .sum(sum1), .cout(cout1), .a(a1), .b(b1), .cin(cin1),
    .sum_q(sum1_q), .cout_q(cout1_q)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf1), .ovf_q(ovf1_q)
`endif
  );

  full_adder #(.WIDTH(4)) u_w4 (
    .clk(clk), .rst_n(rst_n), .sum(sum4), .cout(cout4), .a(a4), .b(b4), .cin(cin4),
    .sum_q(sum4_q), .cout_q(cout4_q)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf4), .ovf_q(ovf4_q)
`endif
  );

  full_adder #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst_n(rst_n), .sum(sum8), .cout(cout8), .a(a8), .b(b8), .cin(cin8),
    .sum_q(sum8_q), .cout_q(cout8_q)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf8), .ovf_q(ovf8_q)
`endif
  );

  full_adder #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst_n(rst_n), .sum(sum16), .cout(cout16), .a(a16), .b(b16), .cin(cin16),
    .sum_q(sum16_q), .cout_q(cout16_q)
`ifdef FULL_ADDER_OVF_EN
    , .ovf(ovf16), .ovf_q(ovf16_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [64:0] got, input logic [64:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // WIDTH=1 truth table as {cout,sum}, indexed by {a,b,cin}.
  logic [1:0] tt [8];

  initial begin
    logic [16:0] gold;

    tt = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};
    n_pass  = 0;
    n_total = 0;
    rst_n = 1'b0;
    {a1, b1, cin1} = 3'b000;
    a4 = 4'h0; b4 = 4'h0; cin4 = 1'b0;
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1;
    a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0;

    // Reset state; combinational path live during reset.
    #3;
    check("rst_sum4_q", 65'(sum4_q), 65'(4'h0));
    check("rst_cout4_q", 65'(cout4_q), 65'(1'b0));
    check("rst_sum8_comb", 65'(sum8), 65'(8'h00));
    check("rst_cout8_comb", 65'(cout8), 65'(1'b1));
`ifdef FULL_ADDER_OVF_EN
    check("rst_ovf8_q", 65'(ovf8_q), 65'(1'b0));
    check("ovf8_ff_00_1", 65'(ovf8), 65'(1'b0));
`endif
    @(posedge clk); #1;
    check("rst_hold_sum8_q", 65'(sum8_q), 65'(8'h00));
    check("rst_hold_cout8_q", 65'(cout8_q), 65'(1'b0));
    @(negedge clk);
    rst_n = 1'b1;

    // WIDTH=1 exhaustive.
    for (int i = 0; i < 8; i++) begin
      {a1, b1, cin1} = 3'(i);
      #1;
      check($sformatf("w1_tt_%0d", i), 65'({cout1, sum1}), 65'(tt[i]));
`ifdef FULL_ADDER_OVF_EN
      check($sformatf("w1_ovf_%0d", i), 65'(ovf1), 65'(tt[i][1] ^ cin1));
`endif
      #9;
    end

    // WIDTH=8 boundaries.
    a8 = 8'hFF; b8 = 8'h00; cin8 = 1'b1; #1;
    check("w8_ff_00_1_sum", 65'(sum8), 65'(8'h00));
    check("w8_ff_00_1_cout", 65'(cout8), 65'(1'b1));
    a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; #1;
    check("w8_7f_01_0_sum", 65'(sum8), 65'(8'h80));
    check("w8_7f_01_0_cout", 65'(cout8), 65'(1'b0));
`ifdef FULL_ADDER_OVF_EN
    check("w8_7f_01_0_ovf", 65'(ovf8), 65'(1'b1));
`endif
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b1; #1;
    check("w8_ff_ff_1", 65'({cout8, sum8}), 65'(9'h1FF));

    // Registered path at WIDTH=4: 9 + 8 + 1 = 0x12.
    @(negedge clk);
    a4 = 4'h9; b4 = 4'h8; cin4 = 1'b1;
    #1;
    check("w4_comb_sum", 65'(sum4), 65'(4'h2));
    check("w4_comb_cout", 65'(cout4), 65'(1'b1));
    check("w4_pre_edge_sum_q", 65'(sum4_q), 65'(4'h0));
    check("w4_pre_edge_cout_q", 65'(cout4_q), 65'(1'b0));
    @(posedge clk); #1;
    check("w4_post_edge_sum_q", 65'(sum4_q), 65'(4'h2));
    check("w4_post_edge_cout_q", 65'(cout4_q), 65'(1'b1));

    // Async reset between edges.
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sum4_q", 65'(sum4_q), 65'(4'h0));
    check("arst_cout4_q", 65'(cout4_q), 65'(1'b0));
    check("arst_sum4_live", 65'(sum4), 65'(4'h2));
    check("arst_cout4_live", 65'(cout4), 65'(1'b1));
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_no_capture_sum4_q", 65'(sum4_q), 65'(4'h0));
    @(posedge clk); #1;
    check("rel_capture_sum4_q", 65'(sum4_q), 65'(4'h2));
    check("rel_capture_cout4_q", 65'(cout4_q), 65'(1'b1));

    // WIDTH=16 pseudo-random against the golden function.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      a16   = 16'($urandom);
      b16   = 16'($urandom);
      cin16 = 1'($urandom);
      if (i == 0) begin a16 = 16'hFFFF; b16 = 16'hFFFF; cin16 = 1'b1; end
      if (i == 1) begin a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; end
      gold = 17'(fa_ref(64'(a16), 64'(b16), cin16));
      #1;
      check($sformatf("w16_comb_%0d", i), 65'({cout16, sum16}), 65'(gold));
      @(posedge clk); #1;
      check($sformatf("w16_reg_%0d", i), 65'({cout16_q, sum16_q}), 65'(gold));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
